stage_sequencer: RTL
====================

// Module: stage_sequencer
// PURPOSE
//  Sequences the 3-stage processor: one-hot phase FSM FETCH -> DECODE -> EXECUTE -> WB (f,d,e,i).
//  Adds a fetch memory handshake, an execute stall input, a halt/resume path and an execute watchdog.
//  Sits between the processor datapath (drives its load/enable strobes) and instruction memory.
// PARAMETERS
//  MAX_EXEC_CYC  16  execute-stall watchdog limit in cycles (>=1); counter width = $clog2(MAX_EXEC_CYC+1)
//  PERF_W        16  width of the performance counters (used only with STAGE_PERF_CNT_EN)
// PORTS
//  clk        in   1       system clock, all state changes on rising edge
//  clr        in   1       synchronous active-high reset
//  ce         in   1       clock enable; 0 freezes all state and gates all strobes low
//  mem_ack    in   1       instruction memory returns word this cycle
//  exec_busy  in   1       datapath needs more execute cycles
//  halt_dec   in   1       decoded instruction is HALT (sampled in DECODE)
//  resume     in   1       leave HALTED (sampled in HALTED)
//  f,d,e,i    out  1 each  one-hot phase outputs FETCH/DECODE/EXECUTE/WB (WB and HALTED both drive i)
//  mem_req    out  1       instruction fetch request
//  ir_load    out  1       load IR / increment PC strobe (1 cycle)
//  wb_en      out  1       register write-back strobe (1 cycle)
//  halted     out  1       sequencer parked in HALTED
//  wd_err     out  1       sticky: execute watchdog expired
//  cyc_cnt    out  PERF_W  cycles with ce=1 since reset
//  instr_cnt  out  PERF_W  instructions retired (wb_en pulses)
// BEHAVIOUR
//  Reset (clr=1 at edge, overrides ce): phase=FETCH (f=1,d=e=i=0), halted=0, wd_err=0, watchdog=0,
//   counters=0. Post-reset outputs: mem_req=1, ir_load=0, wb_en=0. Reset mid-stall/mid-fetch aborts it.
//  All transitions below occur only on edges with ce=1; with ce=0 state holds, ir_load=wb_en=0,
//   mem_req holds its phase-derived value.
//  mem_req = f (combinational from state). ir_load = f & mem_ack & ce. wb_en = i & ~halted & ce.
//  FETCH:   mem_ack=1 -> DECODE; else stay (no timeout).
//  DECODE:  1 cycle; halt_dec=1 -> HALTED (i=1, halted=1); else -> EXECUTE, watchdog cleared.
//  EXECUTE: exec_busy=0 -> WB. exec_busy=1 -> stay, watchdog+1; when watchdog reaches MAX_EXEC_CYC
//           -> WB anyway, wd_err set (sticky until clr).
//  WB:      1 cycle, wb_en=1 -> FETCH.
//  HALTED:  i=1, no strobes, mem_req=0; resume=1 -> FETCH next cycle, halted=0.
//  Minimum instruction latency 4 cycles (mem_ack and ~exec_busy immediate), one instruction retired per WB.
//  Phase outputs are always exactly one-hot; no illegal state reachable. Unreachable encodings -> FETCH.
//  Simultaneous: clr beats everything; mem_ack outside FETCH ignored; resume outside HALTED ignored;
//   halt_dec outside DECODE ignored; exec_busy outside EXECUTE ignored.
// CONFIGURATION
//  STAGE_PERF_CNT_EN defined: cyc_cnt +1 each ce=1 cycle, instr_cnt +1 each wb_en; both wrap modulo 2^PERF_W.
//  Not defined: no counter flops; cyc_cnt and instr_cnt tied to 0; ports remain for a fixed interface.
// STRUCTURE
//  Package stage_pkg: phase one-hot constants PH_FETCH=4'b0001, PH_DECODE=4'b0010, PH_EXEC=4'b0100,
//   PH_WB=4'b1000; PERF_W default.
//  Sub-module phase_ring: 4-bit one-hot ring with hold/advance/load-vector inputs, preset to PH_FETCH on clr;
//   stage_sequencer owns handshake, halt, watchdog and counter logic around it.
// TESTING
//  1 clr=1 for 2 cycles, ce=1 -> f=1,mem_req=1,halted=0,wd_err=0,counters=0.
//  2 mem_ack same cycle, halt_dec=0, exec_busy=0 -> phases f,d,e,i in 4 cycles, one ir_load and one wb_en,
//    instr_cnt=1 (macro on).
//  3 mem_ack delayed 3 cycles -> f held 4 cycles, mem_req=1 throughout, ir_load only on ack cycle.
//  4 exec_busy high 3 cycles -> e held 4 cycles; exec_busy stuck with MAX_EXEC_CYC=16 -> WB after 16 stall
//    cycles, wd_err=1 and stays 1.
//  5 halt_dec=1 in DECODE -> i=1,halted=1,mem_req=0, no wb_en for 10 cycles; resume=1 -> f=1 next cycle.
//  6 ce=0 for 5 cycles mid-EXECUTE, then clr during FETCH wait -> state frozen, no strobes; clr -> FETCH,
//    counters 0.

Source files
------------

// File: rtl/stage_pkg.sv
// ---------------------------------------------------------------------------
// stage_pkg
// Shared definitions for the 3-stage processor sequencer.
//   phase_t        : one-hot phase encodings FETCH/DECODE/EXECUTE/WB
//   PERF_W_DEFAULT : default width of the optional performance counters
//   rotate_phase() : advances a one-hot phase vector to the next stage
// ---------------------------------------------------------------------------
package stage_pkg;

    typedef enum logic [3:0] {
        PH_FETCH  = 4'b0001,
        PH_DECODE = 4'b0010,
        PH_EXEC   = 4'b0100,
        PH_WB     = 4'b1000
    } phase_t;

    localparam int PERF_W_DEFAULT = 16;

    // Rotate left by one: FETCH -> DECODE -> EXEC -> WB -> FETCH.
    function automatic logic [3:0] rotate_phase(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

endpackage

// File: rtl/phase_ring.sv
// ---------------------------------------------------------------------------
// phase_ring
// 4-bit one-hot phase register with hold / advance / load-vector controls.
// Ports:
//   clk      in  system clock
//   clr      in  synchronous active-high reset, presets the ring to PH_FETCH
//   hold     in  1 = keep current phase regardless of advance/load
//   advance  in  rotate to the next phase
//   load     in  load load_vec (wins over advance)
//   load_vec in  phase vector to load
//   phase    out current one-hot phase
// ---------------------------------------------------------------------------
module phase_ring
    import stage_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    input  logic       advance,
    input  logic       load,
    input  logic [3:0] load_vec,
    output logic [3:0] phase
);

    // Phase register: clr wins, then hold freezes, then an explicit load
    // takes priority over a plain rotate.
    always_ff @(posedge clk) begin
        if (clr) begin
            phase <= PH_FETCH;
        end else if (!hold) begin
            if (load) begin
                phase <= load_vec;
            end else if (advance) begin
                phase <= rotate_phase(phase);
            end
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Phase sequencer for the 3-stage processor: FETCH -> DECODE -> EXECUTE -> WB
// with a fetch memory handshake, execute stall, halt/resume and an execute
// watchdog.  HALTED is represented as the WB phase with the halted flag set,
// so i stays high while parked but no write-back strobe is produced.
// Optional feature macro: STAGE_PERF_CNT_EN (cycle / retired-instruction
// counters; without it both counter outputs are tied to zero).
// Ports:
//   clk, clr          clock, synchronous active-high reset
//   ce                clock enable (0 freezes state and gates strobes)
//   mem_ack           instruction memory returns a word this cycle
//   exec_busy         datapath needs more execute cycles
//   halt_dec          decoded instruction is HALT
//   resume            leave HALTED
//   f, d, e, i        one-hot phase outputs
//   mem_req           instruction fetch request
//   ir_load           IR load / PC increment strobe
//   wb_en             register write-back strobe
//   halted            parked in HALTED
//   wd_err            sticky execute-watchdog expiry flag
//   cyc_cnt           cycles with ce=1 since reset
//   instr_cnt         instructions retired
// ---------------------------------------------------------------------------
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int MAX_EXEC_CYC = 16,
    parameter int PERF_W       = PERF_W_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ce,
    input  logic              mem_ack,
    input  logic              exec_busy,
    input  logic              halt_dec,
    input  logic              resume,
    output logic              f,
    output logic              d,
    output logic              e,
    output logic              i,
    output logic              mem_req,
    output logic              ir_load,
    output logic              wb_en,
    output logic              halted,
    output logic              wd_err,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt
);

    localparam int WD_W = $clog2(MAX_EXEC_CYC + 1);

    logic [3:0]      phase;
    logic            ring_advance;
    logic            ring_load;
    logic [3:0]      ring_vec;
    logic            halted_q;
    logic            halted_d;
    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            wd_err_q;
    logic            wd_err_d;

    phase_ring u_ring (
        .clk      (clk),
        .clr      (clr),
        .hold     (~ce),
        .advance  (ring_advance),
        .load     (ring_load),
        .load_vec (ring_vec),
        .phase    (phase)
    );

    // Next-state decisions for the ring plus halt, watchdog and error flags.
    // The watchdog leaves EXECUTE on the stall cycle where it reaches
    // MAX_EXEC_CYC.  Any non-one-hot phase is steered back to FETCH.
    always_comb begin
        ring_advance = 1'b0;
        ring_load    = 1'b0;
        ring_vec     = PH_FETCH;
        halted_d     = 1'b0;
        wd_d         = wd_q;
        wd_err_d     = wd_err_q;
        case (phase)
            PH_FETCH: begin
                ring_advance = mem_ack;
            end
            PH_DECODE: begin
                if (halt_dec) begin
                    ring_load = 1'b1;
                    ring_vec  = PH_WB;
                    halted_d  = 1'b1;
                end else begin
                    ring_advance = 1'b1;
                    wd_d         = '0;
                end
            end
            PH_EXEC: begin
                if (exec_busy) begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_q >= WD_W'(MAX_EXEC_CYC - 1)) begin
                        ring_advance = 1'b1;
                        wd_err_d     = 1'b1;
                    end
                end else begin
                    ring_advance = 1'b1;
                end
            end
            PH_WB: begin
                if (halted_q) begin
                    halted_d = ~resume;
                    if (resume) begin
                        ring_load = 1'b1;
                        ring_vec  = PH_FETCH;
                    end
                end else begin
                    ring_advance = 1'b1;
                end
            end
            default: begin
                ring_load = 1'b1;
                ring_vec  = PH_FETCH;
            end
        endcase
    end

    // Control flops beside the ring; frozen whenever ce is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            halted_q <= 1'b0;
            wd_q     <= '0;
            wd_err_q <= 1'b0;
        end else if (ce) begin
            halted_q <= halted_d;
            wd_q     <= wd_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign f       = phase[0];
    assign d       = phase[1];
    assign e       = phase[2];
    assign i       = phase[3];
    assign mem_req = phase[0];
    assign ir_load = phase[0] & mem_ack & ce;
    assign wb_en   = phase[3] & ~halted_q & ce;
    assign halted  = halted_q;
    assign wd_err  = wd_err_q;

`ifdef STAGE_PERF_CNT_EN
    logic [PERF_W-1:0] cyc_q;
    logic [PERF_W-1:0] instr_q;

    // Free-running performance counters, wrapping modulo 2^PERF_W.
    always_ff @(posedge clk) begin
        if (clr) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else if (ce) begin
            cyc_q <= cyc_q + PERF_W'(1);
            if (wb_en) begin
                instr_q <= instr_q + PERF_W'(1);
            end
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;
`else
    assign cyc_cnt   = '0;
    assign instr_cnt = '0;
`endif

endmodule
